// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the two-cache memory bus arbiter.
package mem_bus_pkg;

  // Transaction sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Memory operation kind latched at grant time.
  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  // Number of caches sharing the memory port.
  localparam int NUM_REQ = 2;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of request, grant, memory and snoop signals between the caches,
// the arbiter and main memory.
//
// Handshake: a cache raises req_rd/req_wr and holds it (with stable
// req_addr/req_wdata) until req_ready pulses for that cache; gnt stays high
// for the whole transaction. Toward memory, rd_mem/wr_mem are held until
// ready_mem is sampled high, which completes the access in that cycle.
interface mem_bus_arbiter_if #(
  parameter int AWIDTH = 9,
  parameter int DWIDTH = 32
);
  logic [1:0]          req_rd;
  logic [1:0]          req_wr;
  logic [2*AWIDTH-1:0] req_addr;
  logic [2*DWIDTH-1:0] req_wdata;
  logic [1:0]          gnt;
  logic [1:0]          req_ready;
  logic                req_err;
  logic [DWIDTH-1:0]   req_rdata;
  logic                rd_mem;
  logic                wr_mem;
  logic [AWIDTH-1:0]   addr_mem;
  logic [DWIDTH-1:0]   data_mem_out;
  logic [DWIDTH-1:0]   data_mem_in;
  logic                ready_mem;
  logic                snoop_valid;
  logic                snoop_wr;
  logic                snoop_src;
  logic [AWIDTH-1:0]   snoop_addr;
  logic                proto_err;

  // Arbiter side.
  modport master (
    input  req_rd, req_wr, req_addr, req_wdata, data_mem_in, ready_mem,
    output gnt, req_ready, req_err, req_rdata, rd_mem, wr_mem, addr_mem,
           data_mem_out, snoop_valid, snoop_wr, snoop_src, snoop_addr,
           proto_err
  );

  // Caches and memory side.
  modport slave (
    output req_rd, req_wr, req_addr, req_wdata, data_mem_in, ready_mem,
    input  gnt, req_ready, req_err, req_rdata, rd_mem, wr_mem, addr_mem,
           data_mem_out, snoop_valid, snoop_wr, snoop_src, snoop_addr,
           proto_err
  );
endinterface

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, on a tie the cache that
// was not granted last wins.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_last_gnt,
  output logic       o_id,
  output logic       o_valid
);

  // Combinational winner selection.
  always_comb begin
    o_valid = |i_req;
    if (&i_req) begin
      o_id = ~i_last_gnt;
    end else begin
      o_id = i_req[1];
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter and transaction sequencer sharing one memory port
// between two caches. One transaction at a time: IDLE picks a winner and
// latches its request, ACCESS holds the memory strobe until ready_mem or
// timeout, DONE returns a one-cycle completion to the winner.
// TIMEOUT must lie in 1..255 so the 8-bit counter can reach TIMEOUT-1.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int AWIDTH  = 9,
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic   clk,
  input  logic   reset,
  mem_bus_arbiter_if.master bus,
  output state_t o_dbg_state
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_last_gnt;
  logic                r_id;
  op_t                 r_op;
  logic [AWIDTH-1:0]   r_addr;
  logic [DWIDTH-1:0]   r_wdata;
  logic [DWIDTH-1:0]   r_rdata;
  logic [7:0]          r_cnt;
  logic                r_err;
  logic                r_proto_err;

  logic [1:0]          w_req;
  logic                w_win_id;
  logic                w_win_valid;
  logic                w_win_rd;
  logic                w_win_wr;
  logic [AWIDTH-1:0]   w_win_addr;
  logic [DWIDTH-1:0]   w_win_wdata;
  logic                w_cnt_last;

  assign w_req       = bus.req_rd | bus.req_wr;
  assign w_win_rd    = bus.req_rd[w_win_id];
  assign w_win_wr    = bus.req_wr[w_win_id];
  assign w_win_addr  = w_win_id ? bus.req_addr[2*AWIDTH-1:AWIDTH]
                                : bus.req_addr[AWIDTH-1:0];
  assign w_win_wdata = w_win_id ? bus.req_wdata[2*DWIDTH-1:DWIDTH]
                                : bus.req_wdata[DWIDTH-1:0];
  assign w_cnt_last  = (r_cnt == CNT_LAST);
  assign o_dbg_state = r_state;

  rr_arb2 u_rr_arb2 (
    .i_req      (w_req),
    .i_last_gnt (r_last_gnt),
    .o_id       (w_win_id),
    .o_valid    (w_win_valid)
  );

  // State register; reset drops any in-flight transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; ready_mem takes priority over timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_win_valid) w_state_nxt = ACCESS;
      ACCESS:  if (bus.ready_mem || w_cnt_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Transaction registers: latch the winner, count ACCESS cycles, capture data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_gnt  <= 1'b1;
      r_id        <= 1'b0;
      r_op        <= OP_RD;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_cnt       <= 8'd0;
      r_err       <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_win_valid) begin
            r_id    <= w_win_id;
            r_op    <= w_win_wr ? OP_WR : OP_RD;
            r_addr  <= w_win_addr;
            r_wdata <= w_win_wdata;
            r_rdata <= '0;
            r_err   <= 1'b0;
            if (w_win_rd && w_win_wr) r_proto_err <= 1'b1;
          end
        end
        ACCESS: begin
          r_cnt <= r_cnt + 8'd1;
          if (bus.ready_mem) begin
            if (r_op == OP_RD) r_rdata <= bus.data_mem_in;
          end else if (w_cnt_last) begin
            r_err <= 1'b1;
          end
        end
        DONE: begin
          r_last_gnt <= r_id;
          r_cnt      <= 8'd0;
        end
        default: ;
      endcase
    end
  end

  // Output decode from the state and latched transaction.
  always_comb begin
    bus.gnt          = 2'b00;
    bus.req_ready    = 2'b00;
    bus.req_err      = 1'b0;
    bus.req_rdata    = '0;
    bus.rd_mem       = 1'b0;
    bus.wr_mem       = 1'b0;
    bus.addr_mem     = '0;
    bus.data_mem_out = '0;
    bus.snoop_valid  = 1'b0;
    bus.snoop_wr     = 1'b0;
    bus.snoop_src    = 1'b0;
    bus.snoop_addr   = '0;
    bus.proto_err    = r_proto_err;
    case (r_state)
      ACCESS: begin
        bus.gnt[r_id]    = 1'b1;
        bus.rd_mem       = (r_op == OP_RD);
        bus.wr_mem       = (r_op == OP_WR);
        bus.addr_mem     = r_addr;
        bus.data_mem_out = (r_op == OP_WR) ? r_wdata : '0;
        // The counter is zero only in the first ACCESS cycle.
        if (r_cnt == 8'd0) begin
          bus.snoop_valid = 1'b1;
          bus.snoop_wr    = (r_op == OP_WR);
          bus.snoop_src   = r_id;
          bus.snoop_addr  = r_addr;
        end
      end
      DONE: begin
        bus.gnt[r_id]       = 1'b1;
        bus.req_ready[r_id] = 1'b1;
        bus.req_err         = r_err;
        bus.req_rdata       = ((r_op == OP_RD) && !r_err) ? r_rdata : '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a short timeout.
module tb_mem_bus_arbiter;
  import mem_bus_pkg::*;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int TO = 8;

  logic   clk = 1'b0;
  logic   reset;
  state_t dbg_state;
  int     n_checks = 0;
  int     n_err = 0;
  int     n;
  logic [1:0] exp_g;

  mem_bus_arbiter_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

  mem_bus_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.master),
    .o_dbg_state (dbg_state)
  );

  // Clock and global time limit.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.req_rd    = 2'b00;
    bus.req_wr    = 2'b00;
    bus.ready_mem = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag, input logic [63:0] exp_proto);
    chk({tag, "_gnt"},       64'(bus.gnt),          64'(0));
    chk({tag, "_ready"},     64'(bus.req_ready),    64'(0));
    chk({tag, "_err"},       64'(bus.req_err),      64'(0));
    chk({tag, "_rdata"},     64'(bus.req_rdata),    64'(0));
    chk({tag, "_rd_mem"},    64'(bus.rd_mem),       64'(0));
    chk({tag, "_wr_mem"},    64'(bus.wr_mem),       64'(0));
    chk({tag, "_addr_mem"},  64'(bus.addr_mem),     64'(0));
    chk({tag, "_dout"},      64'(bus.data_mem_out), 64'(0));
    chk({tag, "_snoop_v"},   64'(bus.snoop_valid),  64'(0));
    chk({tag, "_snoop_a"},   64'(bus.snoop_addr),   64'(0));
    chk({tag, "_proto"},     64'(bus.proto_err),    exp_proto);
    chk({tag, "_state"},     64'(dbg_state),        64'(IDLE));
  endtask

  initial begin
    // Reset.
    reset = 1'b1;
    idle_inputs();
    bus.req_addr    = '0;
    bus.req_wdata   = '0;
    bus.data_mem_in = '0;
    @(negedge clk);
    tick();
    tick();
    chk_all_zero("reset", 64'(0));
    reset = 1'b0;
    tick();

    // Single read from cache 0, memory ready in the third ACCESS cycle.
    bus.req_rd = 2'b01;
    bus.req_addr[AW-1:0] = 9'h004;
    tick();
    chk("rd1_gnt",     64'(bus.gnt),         64'(2'b01));
    chk("rd1_rd_mem1", 64'(bus.rd_mem),      64'(1));
    chk("rd1_wr_mem",  64'(bus.wr_mem),      64'(0));
    chk("rd1_addr1",   64'(bus.addr_mem),    64'(9'h004));
    chk("rd1_snoop_v", 64'(bus.snoop_valid), 64'(1));
    chk("rd1_snoop_s", 64'(bus.snoop_src),   64'(0));
    chk("rd1_snoop_w", 64'(bus.snoop_wr),    64'(0));
    chk("rd1_snoop_a", 64'(bus.snoop_addr),  64'(9'h004));
    tick();
    chk("rd1_rd_mem2", 64'(bus.rd_mem),      64'(1));
    chk("rd1_addr2",   64'(bus.addr_mem),    64'(9'h004));
    chk("rd1_snoop_1", 64'(bus.snoop_valid), 64'(0));
    tick();
    chk("rd1_rd_mem3", 64'(bus.rd_mem),      64'(1));
    chk("rd1_ready_e", 64'(bus.req_ready),   64'(0));
    bus.ready_mem   = 1'b1;
    bus.data_mem_in = 32'hDEADBEEF;
    tick();
    chk("rd1_ready",   64'(bus.req_ready),   64'(2'b01));
    chk("rd1_rdata",   64'(bus.req_rdata),   64'(32'hDEADBEEF));
    chk("rd1_req_err", 64'(bus.req_err),     64'(0));
    chk("rd1_rd_done", 64'(bus.rd_mem),      64'(0));
    chk("rd1_gnt_dn",  64'(bus.gnt),         64'(2'b01));
    idle_inputs();
    tick();
    chk("rd1_idle_rdy", 64'(bus.req_ready),  64'(0));
    chk("rd1_idle_gnt", 64'(bus.gnt),        64'(0));

    // Contention right after reset: strict alternation starting at cache 0.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.req_rd = 2'b11;
    bus.req_addr = {9'h020, 9'h010};
    bus.ready_mem = 1'b1;
    bus.data_mem_in = 32'h000000A5;
    for (int t = 0; t < 4; t++) begin
      exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
      tick();
      chk("cont_gnt",   64'(bus.gnt),       64'(exp_g));
      chk("cont_addr",  64'(bus.addr_mem),  64'((exp_g == 2'b01) ? 9'h010 : 9'h020));
      chk("cont_src",   64'(bus.snoop_src), 64'((exp_g == 2'b01) ? 1'b0 : 1'b1));
      tick();
      chk("cont_ready", 64'(bus.req_ready), 64'(exp_g));
      chk("cont_rdata", 64'(bus.req_rdata), 64'(32'h000000A5));
      tick();
      chk("cont_idle",  64'(dbg_state),     64'(IDLE));
    end
    idle_inputs();
    tick();

    // Write from cache 1.
    bus.req_wr = 2'b10;
    bus.req_addr[2*AW-1:AW] = 9'h1F0;
    bus.req_wdata[2*DW-1:DW] = 32'h12345678;
    tick();
    chk("wr_gnt",     64'(bus.gnt),          64'(2'b10));
    chk("wr_wr_mem",  64'(bus.wr_mem),       64'(1));
    chk("wr_rd_mem",  64'(bus.rd_mem),       64'(0));
    chk("wr_dout",    64'(bus.data_mem_out), 64'(32'h12345678));
    chk("wr_addr",    64'(bus.addr_mem),     64'(9'h1F0));
    chk("wr_snoop_v", 64'(bus.snoop_valid),  64'(1));
    chk("wr_snoop_w", 64'(bus.snoop_wr),     64'(1));
    chk("wr_snoop_a", 64'(bus.snoop_addr),   64'(9'h1F0));
    chk("wr_snoop_s", 64'(bus.snoop_src),    64'(1));
    bus.ready_mem   = 1'b1;
    bus.data_mem_in = 32'hFFFFFFFF;
    tick();
    chk("wr_ready",   64'(bus.req_ready),    64'(2'b10));
    chk("wr_rdata",   64'(bus.req_rdata),    64'(0));
    chk("wr_err",     64'(bus.req_err),      64'(0));
    chk("wr_wr_done", 64'(bus.wr_mem),       64'(0));
    idle_inputs();
    tick();

    // Timeout: memory never answers, ACCESS lasts exactly TO cycles.
    bus.req_rd = 2'b01;
    bus.req_addr[AW-1:0] = 9'h033;
    bus.data_mem_in = 32'h55555555;
    tick();
    n = 0;
    while (dbg_state == ACCESS && n < 20) begin
      chk("to_rd_mem", 64'(bus.rd_mem), 64'(1));
      n++;
      tick();
    end
    chk("to_len",    64'(n),             64'(TO));
    chk("to_ready",  64'(bus.req_ready), 64'(2'b01));
    chk("to_err",    64'(bus.req_err),   64'(1));
    chk("to_rdata",  64'(bus.req_rdata), 64'(0));
    idle_inputs();
    tick();
    bus.req_rd = 2'b01;
    tick();
    bus.ready_mem = 1'b1;
    tick();
    chk("to2_ready", 64'(bus.req_ready), 64'(2'b01));
    chk("to2_err",   64'(bus.req_err),   64'(0));
    chk("to2_rdata", 64'(bus.req_rdata), 64'(32'h55555555));
    idle_inputs();
    tick();

    // Protocol error: rd and wr together from cache 0 becomes a write.
    chk("pe_before", 64'(bus.proto_err), 64'(0));
    bus.req_rd = 2'b01;
    bus.req_wr = 2'b01;
    bus.req_addr[AW-1:0] = 9'h055;
    bus.req_wdata[DW-1:0] = 32'hCAFEF00D;
    tick();
    chk("pe_wr_mem", 64'(bus.wr_mem),       64'(1));
    chk("pe_rd_mem", 64'(bus.rd_mem),       64'(0));
    chk("pe_dout",   64'(bus.data_mem_out), 64'(32'hCAFEF00D));
    chk("pe_snoopw", 64'(bus.snoop_wr),     64'(1));
    chk("pe_flag",   64'(bus.proto_err),    64'(1));
    bus.ready_mem = 1'b1;
    tick();
    chk("pe_ready",  64'(bus.req_ready),    64'(2'b01));
    chk("pe_rdata",  64'(bus.req_rdata),    64'(0));
    idle_inputs();
    tick();
    chk("pe_sticky1", 64'(bus.proto_err),   64'(1));
    bus.req_rd = 2'b01;
    bus.ready_mem = 1'b1;
    tick();
    chk("pe_rd_ok",  64'(bus.rd_mem),       64'(1));
    tick();
    chk("pe_sticky2", 64'(bus.proto_err),   64'(1));
    idle_inputs();
    tick();

    // Reset during ACCESS: transaction dropped, cache 0 wins afterwards.
    bus.req_rd = 2'b11;
    tick();
    chk("rst_pre_gnt", 64'(bus.gnt), 64'(2'b10));
    tick();
    reset = 1'b1;
    tick();
    chk_all_zero("rst_mid", 64'(0));
    tick();
    chk("rst_mid_rdy2", 64'(bus.req_ready), 64'(0));
    reset = 1'b0;
    tick();
    chk("rst_post_gnt", 64'(bus.gnt), 64'(2'b01));
    bus.ready_mem = 1'b1;
    tick();
    chk("rst_post_rdy", 64'(bus.req_ready), 64'(2'b01));
    idle_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
